// File: rtl/meter_pkg.sv
// Shared types, coin amounts and small helpers for the multi-channel parking meter.
package meter_pkg;

  typedef enum logic {
    OP_ADD    = 1'b0,
    OP_PRESET = 1'b1
  } op_e;

  localparam logic [9:0] COIN_0 = 10'd10;
  localparam logic [9:0] COIN_1 = 10'd180;
  localparam logic [9:0] COIN_2 = 10'd200;
  localparam logic [9:0] COIN_3 = 10'd550;

  function automatic logic [9:0] coin_amount(input logic [1:0] code);
    logic [9:0] amt;
    case (code)
      2'd0:    amt = COIN_0;
      2'd1:    amt = COIN_1;
      2'd2:    amt = COIN_2;
      default: amt = COIN_3;
    endcase
    return amt;
  endfunction

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the next shift.
  function automatic logic [15:0] bcd_adj(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    for (int k = 0; k < 4; k++) begin
      if (d[4*k +: 4] >= 4'd5) r[4*k +: 4] = d[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/meter_bin2bcd.sv
// Sequential double-dabble converter: start loads, CW shift steps, then one output step.
// A start while busy restarts the conversion with the new input.
module meter_bin2bcd
  import meter_pkg::*;
#(
  parameter int CW = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [CW-1:0] i_bin,
  output logic          o_busy,
  output logic          o_done,
  output logic [15:0]   o_bcd
);

  localparam int CNT_W = $clog2(CW + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [CW-1:0]    r_bin;
  logic [15:0]      r_work;
  logic [15:0]      r_bcd_out;
  logic [15:0]      w_adj;

  assign w_adj  = bcd_adj(r_work);
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == '0) && !i_start;
  assign o_bcd  = r_bcd_out;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_bin     <= '0;
      r_work    <= '0;
      r_bcd_out <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(CW);
      r_bin  <= i_bin;
      r_work <= '0;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_work <= {w_adj[14:0], r_bin[CW-1]};
        r_bin  <= {r_bin[CW-2:0], 1'b0};
        r_cnt  <= r_cnt - CNT_W'(1);
      end else begin
        r_bcd_out <= r_work;
        r_busy    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_meter.sv
// N-channel parking-meter core: shared 2-stage command pipeline, 1 Hz countdown, BCD/flash display feed.
// Optional METER_AUDIT_EN builds a 32-bit credited-seconds accumulator; otherwise o_audit_total is 0.
module multi_meter
  import meter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CW         = 14,
  parameter int MAX_COUNT  = 9999,
  parameter int TICK_DIV   = 100_000_000,
  parameter int FLASH_HALF = 100_000_000,
  parameter int LOW_THRESH = 200,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [CH_W-1:0]   i_cmd_ch,
  input  logic [1:0]        i_cmd_code,
  input  logic [CW-1:0]     i_cmd_val,
  input  logic [CH_W-1:0]   i_disp_sel,
  output logic [15:0]       o_disp_bcd,
  output logic              o_disp_valid,
  output logic              o_blank,
  output logic [NUM_CH-1:0] o_expired,
  output logic [31:0]       o_audit_total
);

  localparam logic [CW:0] MAX_W = (CW+1)'(MAX_COUNT);

  logic [CW-1:0]   r_count [NUM_CH];
  logic [31:0]     r_tick_cnt;
  logic [31:0]     r_flash_cnt;
  logic            r_phase;
  logic            w_tick;

  logic            r_s1_valid, r_s2_valid;
  op_e             r_s1_op, r_s2_op;
  logic [CH_W-1:0] r_s1_ch, r_s2_ch;
  logic [1:0]      r_s1_code, r_s2_code;
  logic [CW-1:0]   r_s1_val, r_s2_val;
  logic            w_accept;

  logic [CW-1:0]   w_cur, w_post, w_add_new, w_pre_new, w_new;
  logic [CW:0]     w_sum;

  assign w_tick      = (r_tick_cnt == 32'(TICK_DIV - 1));
  assign o_cmd_ready = !r_s1_valid;
  assign w_accept    = i_cmd_valid && !r_s1_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick_cnt  <= '0;
      r_flash_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
      if (r_flash_cnt == 32'(FLASH_HALF - 1)) begin
        r_flash_cnt <= '0;
        r_phase     <= !r_phase;
      end else begin
        r_flash_cnt <= r_flash_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s2_op    <= OP_ADD;
      r_s1_ch    <= '0;
      r_s2_ch    <= '0;
      r_s1_code  <= '0;
      r_s2_code  <= '0;
      r_s1_val   <= '0;
      r_s2_val   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op   <= op_e'(i_cmd_op);
        r_s1_ch   <= i_cmd_ch;
        r_s1_code <= i_cmd_code;
        r_s1_val  <= i_cmd_val;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_op    <= r_s1_op;
      r_s2_ch    <= r_s1_ch;
      r_s2_code  <= r_s1_code;
      r_s2_val   <= r_s1_val;
    end
  end

  // Shared read-modify-write: the tick decrement is folded in before the coin is added.
  assign w_cur     = r_count[r_s2_ch];
  assign w_post    = w_cur - CW'(w_tick && (w_cur != '0));
  assign w_sum     = {1'b0, w_post} + (CW+1)'(coin_amount(r_s2_code));
  assign w_add_new = (w_sum > MAX_W) ? MAX_W[CW-1:0] : w_sum[CW-1:0];
  assign w_pre_new = ({1'b0, r_s2_val} > MAX_W) ? MAX_W[CW-1:0] : r_s2_val;
  assign w_new     = (r_s2_op == OP_PRESET) ? w_pre_new : w_add_new;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_reset) begin
        r_count[i] <= '0;
      end else if (r_s2_valid && (r_s2_ch == CH_W'(i))) begin
        r_count[i] <= w_new;
      end else if (w_tick && (r_count[i] != '0)) begin
        r_count[i] <= r_count[i] - CW'(1);
      end
    end
  end

  always_comb begin
    o_expired = '0;
    for (int i = 0; i < NUM_CH; i++) o_expired[i] = (r_count[i] == '0);
  end

`ifdef METER_AUDIT_EN
  logic [31:0] r_audit;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_audit <= '0;
    else if (r_s2_valid && (r_s2_op == OP_ADD)) r_audit <= r_audit + 32'(w_add_new - w_post);
  end
  assign o_audit_total = r_audit;
`else
  assign o_audit_total = '0;
`endif

  // Display: restart conversion on any change of selection or selected count (and once after reset).
  logic [CW-1:0]   w_sel_cnt, r_cnt_q;
  logic [CH_W-1:0] r_sel_q;
  logic            r_init, r_valid, w_restart, w_bcd_busy, w_bcd_done;

  assign w_sel_cnt = r_count[i_disp_sel];
  assign w_restart = r_init || (i_disp_sel != r_sel_q) || (w_sel_cnt != r_cnt_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_init  <= 1'b1;
      r_sel_q <= '0;
      r_cnt_q <= '0;
      r_valid <= 1'b0;
    end else begin
      r_init  <= 1'b0;
      r_sel_q <= i_disp_sel;
      r_cnt_q <= w_sel_cnt;
      if (w_restart) r_valid <= 1'b0;
      else if (w_bcd_done) r_valid <= 1'b1;
    end
  end

  meter_bin2bcd #(.CW(CW)) u_bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_restart),
    .i_bin   (w_sel_cnt),
    .o_busy  (w_bcd_busy),
    .o_done  (w_bcd_done),
    .o_bcd   (o_disp_bcd)
  );

  assign o_disp_valid = r_valid && !w_bcd_busy && !w_restart;
  assign o_blank      = r_phase && (w_sel_cnt < CW'(LOW_THRESH));

endmodule
